mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one unified memory port between two requesters: instruction fetch (read-only) and the load/store data path.
- Sits between the fetch/decode datapath and a single memory instance. This lets the core run from one memory model instead of separate imem/dmem copies.
- Allows one outstanding transaction at a time.
- Data requests have priority. A bounded starvation counter guarantees fetch progress, and a watchdog flags a memory that never responds.

Parameters:
- AWIDTH, 32, address width
- DWIDTH, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits (must be ≥1)
- TIMEOUT, 64, max cycles waiting for m_rvalid_i before error

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- f_req_i  in  1  fetch request, held until f_gnt_o
- f_addr_i  in  AWIDTH  fetch address
- f_gnt_o  out  1  fetch request accepted this cycle
- f_rvalid_o  out  1  fetch response valid (1-cycle pulse)
- f_rdata_o  out  DWIDTH  fetched instruction
- d_req_i  in  1  data request, held until d_gnt_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  AWIDTH  data address
- d_wdata_i  in  DWIDTH  store data
- d_funct3_i  in  3  access size/sign (RV32 funct3)
- d_gnt_o  out  1  data request accepted
- d_rvalid_o  out  1  data response/ack (1-cycle pulse, loads and stores)
- d_rdata_o  out  DWIDTH  load data
- m_req_o  out  1  memory request
- m_we_o  out  1  memory write enable
- m_addr_o  out  AWIDTH  memory address
- m_wdata_o  out  DWIDTH  memory write data
- m_funct3_o  out  3  memory access size; FUNCT3_LW for fetch
- m_gnt_i  in  1  memory accepted request
- m_rvalid_i  in  1  memory response (every accepted request, including stores)
- m_rdata_i  in  DWIDTH  memory read data
- err_o  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, starve_cnt=0, wait_cnt=0, err_o=0.
  - All outputs are forced to 0 while rst=0.
- States: IDLE, WAIT_F, WAIT_D.
- IDLE selection (combinational):
  - If d_req_i && !(f_req_i && starve_cnt==STARVE_MAX), select data; else if f_req_i, select fetch.
  - m_req_o = selected requester's request. m_addr_o, m_we_o, m_wdata_o and m_funct3_o mux from the selected requester.
  - For fetch: m_we_o=0, m_wdata_o=0, m_funct3_o=FUNCT3_LW.
  - With no request selected, the m_* data fields are 0.
- Grant: f_gnt_o/d_gnt_o = m_gnt_i && (that requester selected). Grant is combinational, in the same cycle as m_gnt_i.
  - Grant moves the state to WAIT_F/WAIT_D at the next edge.
  - A request with no m_gnt_i stays in IDLE. Selection is re-evaluated each cycle, but a requester must hold its fields stable until granted.
- WAIT_x:
  - m_req_o=0 and both grants are 0.
  - On m_rvalid_i: x_rvalid_o=1 and x_rdata_o=m_rdata_i (combinational pass-through) in that cycle; return to IDLE next edge.
  - Minimum request-to-request spacing is 2 cycles when memory responds in the cycle after grant.
- rdata outputs are 0 whenever the matching rvalid output is 0.
- Starvation counter:
  - On a data grant while f_req_i=1: starve_cnt++, saturating at STARVE_MAX.
  - On a fetch grant, or any cycle with f_req_i=0: starve_cnt=0.
  - At STARVE_MAX, a pending fetch wins over data.
- Watchdog:
  - wait_cnt clears on entering WAIT_x and increments each cycle in WAIT_x without m_rvalid_i.
  - When wait_cnt reaches TIMEOUT-1 with no response: err_o←1 (sticky until reset), state←IDLE, no rvalid is issued for that transaction.
- m_rvalid_i in IDLE (spurious or late): ignored; no rvalid outputs.
- Simultaneous m_rvalid_i and the timeout boundary: the response wins; the transaction completes normally and err_o is unchanged.
- Reset mid-transaction: the outstanding response is discarded and the state returns to IDLE.

Decomposition:
- The existing shared package gains mem_arb_state_t (IDLE/WAIT_F/WAIT_D).
- FUNCT3_LW is reused from the existing shared package.
- One sub-module, mem_arb_select: IDLE priority mux plus the starvation counter. Its outputs are sel_fetch and sel_data.
- FSM, watchdog and response steering stay in mem_arbiter.

Test Plan:
- Fetch only: f_addr=0x01000000, m_gnt_i=1; m_rvalid_i 1 cycle later with rdata=0x00000013 -> f_gnt_o pulse, f_rvalid_o=1 with f_rdata_o=0x00000013, d_* stay 0.
- Simultaneous requests with STARVE_MAX=4: d_req (load 0x02000004) and f_req together -> data granted first, m_funct3_o=d_funct3_i; fetch granted after data rvalid.
- Starvation: d_req held continuously, f_req held -> exactly 4 data grants, then a fetch grant, then the counter restarts at 0.
- Store: d_we=1, addr=0x02000008, wdata=0xDEADBEEF, funct3=SW -> m_we_o=1 with matching fields; d_rvalid_o pulse on ack.
- Timeout: grant fetch, hold m_rvalid_i=0 for 64 cycles -> err_o=1 sticky, return to IDLE, no f_rvalid_o; a later m_rvalid_i is ignored.
- Reset in WAIT_D: drive rst=0 asynchronously mid-wait -> all outputs 0 immediately; after release, state is IDLE and the old rvalid is ignored.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: RV32 access-size
// encodings and the arbiter transaction state.
package mem_arbiter_pkg;

   localparam logic [2:0] FUNCT3_LW = 3'b010;
   localparam logic [2:0] FUNCT3_SW = 3'b010;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_F = 2'd1,
      WAIT_D = 2'd2
   } mem_arb_state_t;

endpackage

// File: rtl/mem_arb_select.sv
// IDLE-time requester selection: data has priority unless a waiting fetch
// has been passed over STARVE_MAX times in a row.
module mem_arb_select
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic f_req,
   input  logic d_req,
   input  logic m_gnt,
   output logic sel_fetch,
   output logic sel_data
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt;
   logic             starve_hit;

   always_comb begin
      starve_hit = (starve_cnt == STARVE_LAST);
      sel_data   = enable && d_req && !(f_req && starve_hit);
      sel_fetch  = enable && f_req && !sel_data;
   end

   // Counter only advances on a data grant that overtook a pending fetch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (!f_req || (sel_fetch && m_gnt)) begin
         starve_cnt <= '0;
      end else if (sel_data && m_gnt && !starve_hit) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store traffic onto one memory port with a single
// outstanding transaction, a starvation bound for fetch and a response watchdog.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AWIDTH     = 32,
   parameter int DWIDTH     = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_req_i,
   input  logic [AWIDTH-1:0] f_addr_i,
   output logic              f_gnt_o,
   output logic              f_rvalid_o,
   output logic [DWIDTH-1:0] f_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [AWIDTH-1:0] d_addr_i,
   input  logic [DWIDTH-1:0] d_wdata_i,
   input  logic [2:0]        d_funct3_i,
   output logic              d_gnt_o,
   output logic              d_rvalid_o,
   output logic [DWIDTH-1:0] d_rdata_o,
   output logic              m_req_o,
   output logic              m_we_o,
   output logic [AWIDTH-1:0] m_addr_o,
   output logic [DWIDTH-1:0] m_wdata_o,
   output logic [2:0]        m_funct3_o,
   input  logic              m_gnt_i,
   input  logic              m_rvalid_i,
   input  logic [DWIDTH-1:0] m_rdata_i,
   output logic              err_o
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   mem_arb_state_t    state, state_next;
   logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
   logic              err, err_next;
   logic              sel_fetch, sel_data;
   logic              in_idle;

   assign in_idle = (state == IDLE);

   mem_arb_select #(
      .STARVE_MAX (STARVE_MAX)
   ) u_select (
      .clk       (clk),
      .rst       (rst),
      .enable    (in_idle),
      .f_req     (f_req_i),
      .d_req     (d_req_i),
      .m_gnt     (m_gnt_i),
      .sel_fetch (sel_fetch),
      .sel_data  (sel_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
         err      <= err_next;
      end
   end

   // A response in the timeout cycle still completes the transaction.
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      err_next      = err;
      case (state)
         IDLE: begin
            wait_cnt_next = '0;
            if (m_gnt_i && sel_fetch) begin
               state_next = WAIT_F;
            end else if (m_gnt_i && sel_data) begin
               state_next = WAIT_D;
            end
         end
         WAIT_F, WAIT_D: begin
            if (m_rvalid_i) begin
               state_next = IDLE;
            end else if (wait_cnt == WAIT_LAST) begin
               state_next = IDLE;
               err_next   = 1'b1;
            end else begin
               wait_cnt_next = wait_cnt + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Every output is held low while reset is asserted.
   always_comb begin
      m_req_o    = rst && (sel_fetch || sel_data);
      m_we_o     = 1'b0;
      m_addr_o   = '0;
      m_wdata_o  = '0;
      m_funct3_o = '0;
      if (rst && sel_data) begin
         m_we_o     = d_we_i;
         m_addr_o   = d_addr_i;
         m_wdata_o  = d_wdata_i;
         m_funct3_o = d_funct3_i;
      end else if (rst && sel_fetch) begin
         m_addr_o   = f_addr_i;
         m_funct3_o = FUNCT3_LW;
      end

      f_gnt_o    = rst && m_gnt_i && sel_fetch;
      d_gnt_o    = rst && m_gnt_i && sel_data;
      f_rvalid_o = rst && (state == WAIT_F) && m_rvalid_i;
      d_rvalid_o = rst && (state == WAIT_D) && m_rvalid_i;
      f_rdata_o  = f_rvalid_o ? m_rdata_i : '0;
      d_rdata_o  = d_rvalid_o ? m_rdata_i : '0;
      err_o      = rst && err;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-by-cycle vector table plus
// hand-written starvation, watchdog and reset sequences.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        f_req_i, d_req_i, d_we_i, m_gnt_i, m_rvalid_i;
   logic [31:0] f_addr_i, d_addr_i, d_wdata_i, m_rdata_i;
   logic [2:0]  d_funct3_i;
   logic        f_gnt_o, f_rvalid_o, d_gnt_o, d_rvalid_o, m_req_o, m_we_o, err_o;
   logic [31:0] f_rdata_o, d_rdata_o, m_addr_o, m_wdata_o;
   logic [2:0]  m_funct3_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .AWIDTH(32), .DWIDTH(32), .STARVE_MAX(4), .TIMEOUT(64)
   ) dut (
      .clk(clk), .rst(rst),
      .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o),
      .f_rvalid_o(f_rvalid_o), .f_rdata_o(f_rdata_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
      .d_wdata_i(d_wdata_i), .d_funct3_i(d_funct3_i), .d_gnt_o(d_gnt_o),
      .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
      .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o),
      .m_wdata_o(m_wdata_o), .m_funct3_o(m_funct3_o), .m_gnt_i(m_gnt_i),
      .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i), .err_o(err_o)
   );

   typedef struct packed {
      logic        rst;
      logic        f_req;
      logic [31:0] f_addr;
      logic        d_req;
      logic        d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [2:0]  d_funct3;
      logic        m_gnt;
      logic        m_rvalid;
      logic [31:0] m_rdata;
   } in_t;

   typedef struct packed {
      logic        f_gnt;
      logic        f_rvalid;
      logic [31:0] f_rdata;
      logic        d_gnt;
      logic        d_rvalid;
      logic [31:0] d_rdata;
      logic        m_req;
      logic        m_we;
      logic [31:0] m_addr;
      logic [31:0] m_wdata;
      logic [2:0]  m_funct3;
      logic        err;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   out_t act;
   assign act = {f_gnt_o, f_rvalid_o, f_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
                 m_req_o, m_we_o, m_addr_o, m_wdata_o, m_funct3_o, err_o};

   function automatic in_t vin(logic r, logic fq, logic [31:0] fa, logic dq, logic dwe,
                               logic [31:0] da, logic [31:0] dwd, logic [2:0] df3,
                               logic mg, logic mrv, logic [31:0] mrd);
      in_t v;
      v.rst = r; v.f_req = fq; v.f_addr = fa; v.d_req = dq; v.d_we = dwe;
      v.d_addr = da; v.d_wdata = dwd; v.d_funct3 = df3;
      v.m_gnt = mg; v.m_rvalid = mrv; v.m_rdata = mrd;
      return v;
   endfunction

   function automatic out_t vout(logic fg, logic frv, logic [31:0] frd, logic dg, logic drv,
                                 logic [31:0] drd, logic mrq, logic mwe, logic [31:0] ma,
                                 logic [31:0] mwd, logic [2:0] mf3, logic e);
      out_t o;
      o.f_gnt = fg; o.f_rvalid = frv; o.f_rdata = frd; o.d_gnt = dg; o.d_rvalid = drv;
      o.d_rdata = drd; o.m_req = mrq; o.m_we = mwe; o.m_addr = ma; o.m_wdata = mwd;
      o.m_funct3 = mf3; o.err = e;
      return o;
   endfunction

   task automatic apply(input in_t v);
      rst = v.rst; f_req_i = v.f_req; f_addr_i = v.f_addr; d_req_i = v.d_req;
      d_we_i = v.d_we; d_addr_i = v.d_addr; d_wdata_i = v.d_wdata;
      d_funct3_i = v.d_funct3; m_gnt_i = v.m_gnt; m_rvalid_i = v.m_rvalid;
      m_rdata_i = v.m_rdata;
   endtask

   task automatic check_out(input string name, input out_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] a, input logic [31:0] e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, a, e);
      end
   endtask

   vec_t vecs[$];
   in_t  quiet;

   initial begin
      quiet = vin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);

      // reset: every output forced low regardless of inputs
      vecs.push_back('{vin(0, 1, 32'h0100_0000, 1, 1, 32'h0200_0000, 32'h1111_1111, 3'd2, 1, 1, 32'hFF),
                       vout(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
      // fetch only
      vecs.push_back('{vin(1, 1, 32'h0100_0000, 0, 0, 0, 0, 0, 1, 0, 0),
                       vout(1, 0, 0, 0, 0, 0, 1, 0, 32'h0100_0000, 0, 3'd2, 0)});
      vecs.push_back('{vin(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0013),
                       vout(0, 1, 32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
      // spurious response in IDLE
      vecs.push_back('{vin(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0055),
                       vout(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
      // simultaneous: data selected, stalled then granted
      vecs.push_back('{vin(1, 1, 32'h0100_0004, 1, 0, 32'h0200_0004, 0, 3'd4, 0, 0, 0),
                       vout(0, 0, 0, 0, 0, 0, 1, 0, 32'h0200_0004, 0, 3'd4, 0)});
      vecs.push_back('{vin(1, 1, 32'h0100_0004, 1, 0, 32'h0200_0004, 0, 3'd4, 1, 0, 0),
                       vout(0, 0, 0, 1, 0, 0, 1, 0, 32'h0200_0004, 0, 3'd4, 0)});
      // WAIT_D: no request or grant even with m_gnt high
      vecs.push_back('{vin(1, 1, 32'h0100_0004, 0, 0, 0, 0, 0, 1, 0, 0),
                       vout(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
      vecs.push_back('{vin(1, 1, 32'h0100_0004, 0, 0, 0, 0, 0, 0, 1, 32'h0000_00AB),
                       vout(0, 0, 0, 0, 1, 32'h0000_00AB, 0, 0, 0, 0, 0, 0)});
      vecs.push_back('{vin(1, 1, 32'h0100_0004, 0, 0, 0, 0, 0, 1, 0, 0),
                       vout(1, 0, 0, 0, 0, 0, 1, 0, 32'h0100_0004, 0, 3'd2, 0)});
      vecs.push_back('{vin(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0010_0093),
                       vout(0, 1, 32'h0010_0093, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
      // store
      vecs.push_back('{vin(1, 0, 0, 1, 1, 32'h0200_0008, 32'hDEAD_BEEF, 3'd2, 1, 0, 0),
                       vout(0, 0, 0, 1, 0, 0, 1, 1, 32'h0200_0008, 32'hDEAD_BEEF, 3'd2, 0)});
      vecs.push_back('{vin(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678),
                       vout(0, 0, 0, 0, 1, 32'h1234_5678, 0, 0, 0, 0, 0, 0)});
      vecs.push_back('{quiet, vout(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});

      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clk);
         apply(vecs[k].i);
         #1;
         check_out($sformatf("vec%0d", k), vecs[k].o);
      end

      // starvation: 4 data grants, then fetch, then the count restarts
      @(negedge clk);
      apply(quiet);
      f_req_i = 1; f_addr_i = 32'h0100_0100;
      d_req_i = 1; d_addr_i = 32'h0200_0010; d_funct3_i = 3'd2;
      for (int r = 0; r < 10; r++) begin
         m_gnt_i = 1; m_rvalid_i = 0;
         #1;
         check32($sformatf("starve_r%0d_fgnt", r), {31'd0, f_gnt_o}, (r == 4 || r == 9) ? 1 : 0);
         check32($sformatf("starve_r%0d_dgnt", r), {31'd0, d_gnt_o}, (r == 4 || r == 9) ? 0 : 1);
         @(negedge clk);
         m_gnt_i = 0; m_rvalid_i = 1; m_rdata_i = 32'h100 + r;
         #1;
         if (r == 4 || r == 9)
            check32($sformatf("starve_r%0d_frdata", r), f_rdata_o, 32'h100 + r);
         else
            check32($sformatf("starve_r%0d_drdata", r), d_rdata_o, 32'h100 + r);
         @(negedge clk);
      end
      apply(quiet);

      // response in the final watchdog cycle completes normally
      @(negedge clk);
      f_req_i = 1; f_addr_i = 32'h0100_0200; m_gnt_i = 1;
      #1;
      check32("wd_edge_gnt", {31'd0, f_gnt_o}, 1);
      @(posedge clk); #1;
      f_req_i = 0; m_gnt_i = 0;
      repeat (63) @(posedge clk);
      @(negedge clk);
      m_rvalid_i = 1; m_rdata_i = 32'h0000_BEEF;
      #1;
      check32("wd_edge_rdata", f_rdata_o, 32'h0000_BEEF);
      @(negedge clk);
      m_rvalid_i = 0;
      #1;
      check32("wd_edge_err", {31'd0, err_o}, 0);

      // timeout: 64 silent cycles raise sticky err, no rvalid
      @(negedge clk);
      f_req_i = 1; f_addr_i = 32'h0100_0300; m_gnt_i = 1;
      @(posedge clk); #1;
      f_req_i = 0; m_gnt_i = 0;
      repeat (63) @(posedge clk);
      @(negedge clk); #1;
      check32("to_last_cycle_err", {31'd0, err_o}, 0);
      check32("to_last_cycle_mreq", {31'd0, m_req_o}, 0);
      @(negedge clk); #1;
      check32("to_err_set", {31'd0, err_o}, 1);
      m_rvalid_i = 1; m_rdata_i = 32'h0000_0077;
      #1;
      check32("to_late_rvalid", {30'd0, f_rvalid_o, d_rvalid_o}, 0);
      @(negedge clk);
      m_rvalid_i = 0; f_req_i = 1;
      #1;
      check32("to_idle_mreq", {31'd0, m_req_o}, 1);
      check32("to_err_sticky", {31'd0, err_o}, 1);

      // asynchronous reset in WAIT_D
      @(negedge clk);
      apply(quiet);
      d_req_i = 1; d_addr_i = 32'h0200_0020; d_funct3_i = 3'd2; m_gnt_i = 1;
      #1;
      check32("rst_wd_dgnt", {31'd0, d_gnt_o}, 1);
      @(posedge clk); #1;
      d_req_i = 0; m_gnt_i = 0;
      @(negedge clk);
      rst = 0; m_rvalid_i = 1; m_rdata_i = 32'hCAFE_F00D;
      d_req_i = 1; f_req_i = 1; m_gnt_i = 1;
      #1;
      check_out("rst_mid_wait", vout(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      d_req_i = 0; f_req_i = 0; m_gnt_i = 0;
      #1;
      rst = 1;
      #1;
      check32("rst_old_rvalid", {30'd0, f_rvalid_o, d_rvalid_o}, 0);
      check32("rst_err_clear", {31'd0, err_o}, 0);
      @(negedge clk);
      m_rvalid_i = 0; d_req_i = 1; d_addr_i = 32'h0200_0024;
      #1;
      check32("rst_idle_maddr", m_addr_o, 32'h0200_0024);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
